mem_req_master: RTL and testbench

Load/store initiator for the M stage. It decodes the memory opcode in IR_M and issues one request per load or store to a word-organised data memory. The request uses a req/ack handshake with byte enables. Loads are returned sign- or zero-extended, and the pipeline is stalled while a request is outstanding. Misaligned accesses are flagged as address exceptions, and no bus request is made for them.

---
 rtl/mem_req_master.sv | 196 +++++++++++++++++++
 tb/tb_mem_req_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_master.sv
// M-stage load/store initiator: decodes IR_M, issues one req/ack bus access per
// memory op, extends load data and stalls the pipe. Optional timeout: MEM_REQ_TIMEOUT_EN.
module mem_req_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Valid_M,
  input  logic [31:0] IR_M,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemData,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        Done,
  output logic        AdEL,
  output logic        AdES,
  output logic        BusErr,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [3:0]  BusBe,
  output logic [31:0] BusWData,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e      state_q;
  logic        is_load_q, sgn_q;
  size_e       size_q;
  logic [1:0]  lane_q;
  logic        done_q, adel_q, ades_q;
  logic [31:0] load_data_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  cnt_q;
  logic        buserr_q;
`endif

  logic        is_mem, is_load, sgn, misaligned;
  size_e       size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        unused_ir;

  assign unused_ir = ^IR_M[25:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    is_mem  = 1'b1;
    is_load = 1'b0;
    sgn     = 1'b0;
    size    = SZ_W;
    case (IR_M[31:26])
      6'b100000: begin is_load = 1'b1; sgn = 1'b1; size = SZ_B; end
      6'b100100: begin is_load = 1'b1;             size = SZ_B; end
      6'b100001: begin is_load = 1'b1; sgn = 1'b1; size = SZ_H; end
      6'b100101: begin is_load = 1'b1;             size = SZ_H; end
      6'b100011: begin is_load = 1'b1;             size = SZ_W; end
      6'b101000: size = SZ_B;
      6'b101001: size = SZ_H;
      6'b101011: size = SZ_W;
      default:   is_mem = 1'b0;
    endcase

    misaligned = ((size == SZ_W) && (MemAddr[1:0] != 2'b00)) ||
                 ((size == SZ_H) && MemAddr[0]);

    case (size)
      SZ_B:    begin be_d = 4'b0001 << MemAddr[1:0];            wdata_d = {4{MemData[7:0]}};  end
      SZ_H:    begin be_d = MemAddr[1] ? 4'b1100 : 4'b0011;     wdata_d = {2{MemData[15:0]}}; end
      default: begin be_d = 4'b1111;                            wdata_d = MemData;            end
    endcase
  end

  // Lane select and extension of the returned word, steered by the latched address.
  always_comb begin
    byte_v = BusRData[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? BusRData[31:16] : BusRData[15:0];
    case (size_q)
      SZ_B:    load_ext = {{24{sgn_q & byte_v[7]}}, byte_v};
      SZ_H:    load_ext = {{16{sgn_q & half_v[15]}}, half_v};
      default: load_ext = BusRData;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      is_load_q   <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= SZ_W;
      lane_q      <= 2'b00;
      done_q      <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      load_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      cnt_q       <= '0;
      buserr_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (Valid_M && is_mem) begin
            is_load_q <= is_load;
            sgn_q     <= sgn;
            size_q    <= size;
            lane_q    <= MemAddr[1:0];
            if (misaligned) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              adel_q  <= is_load;
              ades_q  <= ~is_load;
            end else begin
              state_q     <= REQ;
              bus_req_q   <= 1'b1;
              bus_we_q    <= ~is_load;
              bus_addr_q  <= {MemAddr[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
`ifdef MEM_REQ_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (BusAck) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            load_data_q <= is_load_q ? load_ext : 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
          end else if (cnt_q == TimeoutLast) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            buserr_q    <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        default: begin
          state_q     <= IDLE;
          done_q      <= 1'b0;
          adel_q      <= 1'b0;
          ades_q      <= 1'b0;
          load_data_q <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
          buserr_q    <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign Stall    = ((state_q == IDLE) && Valid_M && is_mem) || (state_q == REQ);
  assign Done     = done_q;
  assign AdEL     = adel_q;
  assign AdES     = ades_q;
  assign LoadData = load_data_q;
  assign BusReq   = bus_req_q;
  assign BusWe    = bus_we_q;
  assign BusAddr  = bus_addr_q;
  assign BusBe    = bus_be_q;
  assign BusWData = bus_wdata_q;
`ifdef MEM_REQ_TIMEOUT_EN
  assign BusErr   = buserr_q;
`else
  assign BusErr   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: directed vector table, multi-cycle corner
// sequences and randomized accesses against a byte-lane reference model.
module tb_mem_req_master;

  localparam int TO = 4;
  localparam logic [5:0] OP_LB = 6'b100000, OP_LBU = 6'b100100, OP_LH = 6'b100001,
                         OP_LHU = 6'b100101, OP_LW = 6'b100011, OP_SB = 6'b101000,
                         OP_SH = 6'b101001, OP_SW = 6'b101011;

  logic        Clk = 1'b0, Reset = 1'b0, Valid_M = 1'b0;
  logic [31:0] IR_M = '0, MemAddr = '0, MemData = '0, BusRData = '0;
  logic        BusAck = 1'b0;
  logic        Stall, Done, AdEL, AdES, BusErr, BusReq, BusWe;
  logic [31:0] LoadData, BusAddr, BusWData;
  logic [3:0]  BusBe;

  int tests = 0;
  int fails = 0;

  mem_req_master #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Valid_M(Valid_M), .IR_M(IR_M), .MemAddr(MemAddr),
    .MemData(MemData), .Stall(Stall), .LoadData(LoadData), .Done(Done), .AdEL(AdEL),
    .AdES(AdES), .BusErr(BusErr), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
    .BusBe(BusBe), .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] ld;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        adel, ades, buserr;
    int          req_cycles;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr, data, rdata;
    int          dly;
    logic [31:0] ld;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        adel, ades;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int op_bytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Reference: an access of n bytes touches n consecutive byte lanes starting at addr%4.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] rdata,
                                 input int dly);
    exp_t        e;
    int          n, lane;
    longint      mask, v, w;
    bit          mis;
    n    = op_bytes(op);
    lane = int'(addr % 4);
    mask = (64'd1 << (8 * n)) - 1;
    mis  = (addr % n) != 0;
    e.be = 4'(((1 << n) - 1) << lane);
    w = 0;
    for (int k = 0; k < 4 / n; k++) w = w | ((longint'(data) & mask) << (8 * n * k));
    e.wd = 32'(w);
    e.adel = mis && op_is_load(op);
    e.ades = mis && !op_is_load(op);
    e.buserr = 1'b0;
    e.req_cycles = mis ? 0 : dly + 1;
`ifdef MEM_REQ_TIMEOUT_EN
    if (!mis && e.req_cycles > TO) begin
      e.req_cycles = TO;
      e.buserr = 1'b1;
    end
`endif
    e.ld = '0;
    if (op_is_load(op) && !mis && !e.buserr) begin
      v = (longint'(rdata) >> (8 * lane)) & mask;
      if ((op == OP_LB || op == OP_LH) && v[8*n-1]) v = v | ~mask;
      e.ld = 32'(v);
    end
    return e;
  endfunction

  // Called at ~1 time unit after a posedge with the DUT idle; returns likewise.
  task automatic run_access(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdata,
                            input int dly, input exp_t e);
    int  cyc, req;
    bit  got_done, bus_ok, mis;
    logic [31:0] ld_s;
    logic adel_s, ades_s, err_s, stall_s, req_s;
    mis = e.adel || e.ades;
    Valid_M = 1'b1;
    IR_M    = {op, 26'(($urandom))};
    MemAddr = addr;
    MemData = data;
    BusAck  = 1'($urandom);
    BusRData = $urandom;
    #1;
    check({tag, ".stall_accept"}, Stall, 1'b1);
    cyc = 0; req = 0; got_done = 0; bus_ok = 1;
    ld_s = '0; adel_s = 0; ades_s = 0; err_s = 0; stall_s = 0; req_s = 0;
    while (cyc < 300 && !got_done) begin
      @(posedge Clk); #1;
      cyc++;
      BusAck = 1'b0;
      if (Done) begin
        got_done = 1;
        ld_s = LoadData; adel_s = AdEL; ades_s = AdES; err_s = BusErr;
        stall_s = Stall; req_s = BusReq;
      end else if (BusReq) begin
        req++;
        if (BusWe !== !op_is_load(op) || BusAddr !== {addr[31:2], 2'b00} ||
            BusBe !== e.be || Stall !== 1'b1 ||
            (!op_is_load(op) && BusWData !== e.wd)) bus_ok = 0;
        if (req == dly + 1) begin
          BusAck = 1'b1;
          BusRData = rdata;
        end else begin
          BusRData = $urandom;
        end
      end
    end
    check({tag, ".done_seen"}, got_done, 1'b1);
    check({tag, ".latency"}, cyc, mis ? 1 : e.req_cycles + 1);
    check({tag, ".req_cycles"}, req, e.req_cycles);
    if (!mis) check({tag, ".bus_fields"}, bus_ok, 1'b1);
    check({tag, ".load_data"}, ld_s, e.ld);
    check({tag, ".adel_ades_err"}, {adel_s, ades_s, err_s}, {e.adel, e.ades, e.buserr});
    check({tag, ".done_stall_req"}, {stall_s, req_s}, 2'b00);
    @(posedge Clk); #1;
    Valid_M = 1'b0;
    BusAck  = 1'b0;
    check({tag, ".done_pulse"}, {Done, BusReq}, 2'b00);
  endtask

  vec_t vecs[$];
  exp_t e;
  bit   seen;

  initial begin
    vecs.push_back('{OP_LB,  32'h0000_0003, 32'h0,          32'h80FF_0000, 0, 32'hFFFF_FF80, 4'b1000, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{OP_SH,  32'h0000_0012, 32'h1234_ABCD,  32'h0,         3, 32'h0,         4'b1100, 32'hABCD_ABCD,  1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'h0000_0006, 32'h0,          32'h0,         0, 32'h0,         4'b1111, 32'h0,          1'b1, 1'b0});
    vecs.push_back('{OP_SW,  32'h0000_0001, 32'h5555_AAAA,  32'h0,         0, 32'h0,         4'b1111, 32'h5555_AAAA,  1'b0, 1'b1});
    vecs.push_back('{OP_LHU, 32'h0000_0000, 32'h0,          32'h0000_F00F, 0, 32'h0000_F00F, 4'b0011, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{OP_SB,  32'h0000_0041, 32'h0000_00A5,  32'h0,         1, 32'h0,         4'b0010, 32'hA5A5_A5A5,  1'b0, 1'b0});
    vecs.push_back('{OP_LH,  32'h0000_0102, 32'h0,          32'h8001_1234, 0, 32'hFFFF_8001, 4'b1100, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{OP_LBU, 32'h0000_0202, 32'h0,          32'h00AB_0000, 2, 32'h0000_00AB, 4'b0100, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{OP_LW,  32'hFFFF_FFF8, 32'h0,          32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0,          1'b0, 1'b0});
    vecs.push_back('{OP_LH,  32'h0000_0001, 32'h0,          32'h0,         0, 32'h0,         4'b0011, 32'h0,          1'b1, 1'b0});
    vecs.push_back('{OP_SH,  32'h0000_0003, 32'h0,          32'h0,         0, 32'h0,         4'b1100, 32'h0,          1'b0, 1'b1});

    #12;
    check("reset.outputs", {Stall, Done, AdEL, AdES, BusErr, BusReq, BusWe}, 7'b0);
    check("reset.load_data", LoadData, 32'h0);
    check("reset.bus", {BusAddr, BusBe} , 36'h0);
    check("reset.wdata", BusWData, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    foreach (vecs[i]) begin
      e.ld = vecs[i].ld; e.be = vecs[i].be; e.wd = vecs[i].wd;
      e.adel = vecs[i].adel; e.ades = vecs[i].ades; e.buserr = 1'b0;
      e.req_cycles = (vecs[i].adel || vecs[i].ades) ? 0 : vecs[i].dly + 1;
      run_access($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data,
                 vecs[i].rdata, vecs[i].dly, e);
    end

    // Non-memory opcode, and a memory opcode without Valid_M: no stall, no bus activity.
    Valid_M = 1'b1; IR_M = 32'h0000_1234; MemAddr = 32'h10;
    #1; check("nonmem.stall", Stall, 1'b0);
    seen = 0;
    repeat (3) begin @(posedge Clk); #1; seen |= BusReq | Done | Stall; end
    check("nonmem.quiet", seen, 1'b0);
    Valid_M = 1'b0; IR_M = {OP_LW, 26'h0};
    #1; check("invalid.stall", Stall, 1'b0);
    seen = 0;
    repeat (3) begin @(posedge Clk); #1; seen |= BusReq | Done; end
    check("invalid.quiet", seen, 1'b0);

    // Reset in the middle of a request: access dropped, late ack ignored.
    Valid_M = 1'b1; IR_M = {OP_LW, 26'h0}; MemAddr = 32'h100;
    @(posedge Clk); #1;
    check("rst.req_up", BusReq, 1'b1);
    Reset = 1'b0;
    #1; check("rst.req_async_drop", BusReq, 1'b0);
    Valid_M = 1'b0; BusAck = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b1;
    seen = 0;
    repeat (3) begin @(posedge Clk); #1; seen |= BusReq | Done; end
    check("rst.no_done_late_ack", seen, 1'b0);
    BusAck = 1'b0;
    e = model(OP_LW, 32'h104, 32'h0, 32'h0BAD_F00D, 0);
    run_access("rst.after", OP_LW, 32'h104, 32'h0, 32'h0BAD_F00D, 0, e);

`ifdef MEM_REQ_TIMEOUT_EN
    e = model(OP_LW, 32'h20, 32'h0, 32'h1111_2222, 100);
    run_access("to.abort", OP_LW, 32'h20, 32'h0, 32'h1111_2222, 100, e);
    e = model(OP_LW, 32'h24, 32'h0, 32'h3333_4444, TO - 1);
    run_access("to.ack_last", OP_LW, 32'h24, 32'h0, 32'h3333_4444, TO - 1, e);
`endif

    for (int r = 0; r < 40; r++) begin
      logic [5:0]  ops [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
      logic [5:0]  op;
      logic [31:0] a, d, rd;
      int          dl;
      op = ops[$urandom_range(0, 7)];
      a = $urandom; d = $urandom; rd = $urandom;
      dl = $urandom_range(0, 2);
      e = model(op, a, d, rd, dl);
      run_access($sformatf("rnd%0d", r), op, a, d, rd, dl, e);
      repeat ($urandom_range(0, 1)) begin @(posedge Clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
